// File: rtl/pwm_pkg.sv
// Shared constants for the PWM peripheral and its SPI register block: register map,
// default divider, full-scale duty value and the per-pin output mux helper.
package pwm_pkg;

    localparam int         CLK_DIV_DEFAULT  = 13;
    localparam int         PWM_BITS_DEFAULT = 8;
    localparam int         NUM_PINS         = 16;
    localparam logic [7:0] PWM_DUTY_FULL    = 8'hFF;

    // Register addresses shared with the SPI register block.
    typedef enum logic [2:0] {
        REG_EN_OUT_LO = 3'd1,
        REG_EN_OUT_HI = 3'd2,
        REG_EN_PWM_LO = 3'd3,
        REG_EN_PWM_HI = 3'd4,
        REG_DUTY      = 3'd5
    } pwm_reg_e;

    typedef struct packed {
        logic [NUM_PINS-1:0] oe;
        logic [NUM_PINS-1:0] pe;
    } pin_cfg_t;

    // A disabled pin is low whatever its mode bit says.
    function automatic logic [NUM_PINS-1:0] pin_drive(input pin_cfg_t cfg, input logic level);
        return cfg.oe & (~cfg.pe | {NUM_PINS{level}});
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: clock prescaler and free-running PWM counter.
// wrap flags the step that moves the counter from its maximum back to zero.
module pwm_timebase import pwm_pkg::*; #(
    parameter int CLK_DIV  = CLK_DIV_DEFAULT,
    parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PWM_BITS-1:0] cnt,
    output logic                wrap
);

    localparam int                PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(CLK_DIV - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX = {PWM_BITS{1'b1}};

    logic [PS_W-1:0] prescaler;
    logic            step;

    // With CLK_DIV=1 the prescaler is stuck at 0 and step is permanently high.
    assign step = (prescaler == PS_LAST);
    assign wrap = step && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            cnt       <= '0;
        end else begin
            prescaler <= step ? '0 : prescaler + PS_W'(1);
            if (step)
                cnt <= cnt + PWM_BITS'(1);
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin PWM peripheral: each pin off, static on, or driven by one shared duty compare.
// Define PWM_DUTY_SHADOW_EN to latch duty only at period start (glitch-free updates).
module pwm_peripheral import pwm_pkg::*; #(
    parameter int CLK_DIV  = CLK_DIV_DEFAULT,
    parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          en_out_lo,
    input  logic [7:0]          en_out_hi,
    input  logic [7:0]          en_pwm_lo,
    input  logic [7:0]          en_pwm_hi,
    input  logic [PWM_BITS-1:0] duty,
    output logic [NUM_PINS-1:0] pwm_out,
    output logic                period_start
);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_active;
    logic                wrap;
    logic                pwm_level;
    pin_cfg_t            cfg;

    pwm_timebase #(
        .CLK_DIV  (CLK_DIV),
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (pwm_cnt),
        .wrap  (wrap)
    );

`ifdef PWM_DUTY_SHADOW_EN
    // Loaded on the wrap step so the new value is in place when pwm_cnt reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            duty_active <= '0;
        else if (wrap)
            duty_active <= duty;
    end
`else
    assign duty_active = duty;
`endif

    assign cfg.oe = {en_out_hi, en_out_lo};
    assign cfg.pe = {en_pwm_hi, en_pwm_lo};

    // 0xFF is special-cased so full scale is truly 100%, not 255/256.
    assign pwm_level = (duty_active == PWM_DUTY_FULL) || (pwm_cnt < duty_active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= pin_drive(cfg, pwm_level);
            period_start <= wrap;
        end
    end

endmodule
